// File: rtl/ofs_plat_avalon_mem_protocol_checker_pkg.sv
// Shared constants and types for the Avalon-MM protocol checker.
package ofs_plat_avalon_mem_checker_pkg;

    localparam int N_ERR     = 8;
    localparam int ERR_IDX_W = 3;

    // Bit positions in err_flags; lower index wins when several fire together.
    localparam int ERR_RD_WR_BOTH     = 0;
    localparam int ERR_BURST_ZERO     = 1;
    localparam int ERR_RD_IN_WR_BURST = 2;
    localparam int ERR_WR_BC_CHANGE   = 3;
    localparam int ERR_RD_UNDERFLOW   = 4;
    localparam int ERR_RD_OVERFLOW    = 5;
    localparam int ERR_ALLOWANCE      = 6;
    localparam int ERR_RD_TIMEOUT     = 7;

    typedef logic [N_ERR-1:0] t_err_vec;

    // Index of the lowest set bit (0 when none are set).
    function automatic logic [ERR_IDX_W-1:0] first_err_idx(input t_err_vec v);
        first_err_idx = '0;
        for (int i = N_ERR - 1; i >= 0; i--) begin
            if (v[i]) first_err_idx = ERR_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/ofs_plat_avalon_mem_protocol_checker_if.sv
// Avalon-MM command/response link as seen by master, slave and a passive tap.
interface ofs_plat_avalon_mem_protocol_checker_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_CNT_WIDTH = 7
);
    logic                       waitrequest;
    logic                       read;
    logic                       write;
    logic                       readdatavalid;
    logic [ADDR_WIDTH-1:0]      address;
    logic [BURST_CNT_WIDTH-1:0] burstcount;

    modport master (
        input  waitrequest, readdatavalid,
        output read, write, address, burstcount
    );

    modport slave (
        output waitrequest, readdatavalid,
        input  read, write, address, burstcount
    );

    // Observe-only view: the checker never drives the link.
    modport monitor (
        input waitrequest, read, write, readdatavalid, address, burstcount
    );

endinterface

// File: rtl/ofs_plat_avalon_mem_protocol_checker_wr_tracker.sv
// Write-burst tracker: remaining beats, burst length of the open burst,
// and per-beat SOP / burst-length-change / zero-length indications.
module ofs_plat_avalon_mem_checker_wr_tracker #(
    parameter int BURST_CNT_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_acc,
    input  logic [BURST_CNT_WIDTH-1:0] burstcount,
    output logic                       sop,
    output logic                       bc_change,
    output logic                       burst_zero,
    output logic                       in_burst
);
    logic [BURST_CNT_WIDTH-1:0] wr_rem, wr_rem_nxt;
    logic [BURST_CNT_WIDTH-1:0] wr_bc, wr_bc_nxt;

    assign sop        = (wr_rem == '0);
    assign burst_zero = wr_acc && sop && (burstcount == '0);
    assign bc_change  = wr_acc && !sop && (burstcount != wr_bc);

    // Next burst state; a zero-length SOP is treated as a single beat so a
    // bad burstcount cannot open a huge phantom burst.
    always_comb begin
        wr_rem_nxt = wr_rem;
        wr_bc_nxt  = wr_bc;
        if (wr_acc) begin
            if (sop) begin
                wr_rem_nxt = burst_zero ? '0 : burstcount - BURST_CNT_WIDTH'(1);
                wr_bc_nxt  = burstcount;
            end else begin
                wr_rem_nxt = wr_rem - BURST_CNT_WIDTH'(1);
            end
        end
    end

    // Burst state registers; in_burst is kept as its own flop so it is a clean output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_rem   <= '0;
            wr_bc    <= '0;
            in_burst <= 1'b0;
        end else begin
            wr_rem   <= wr_rem_nxt;
            wr_bc    <= wr_bc_nxt;
            in_burst <= (wr_rem_nxt != '0);
        end
    end

endmodule

// File: rtl/ofs_plat_avalon_mem_protocol_checker.sv
// Passive Avalon-MM protocol checker with sticky error flags, first-error
// code and cycle stamp, read-beat accounting and read timeout.
module ofs_plat_avalon_mem_protocol_checker
    import ofs_plat_avalon_mem_checker_pkg::*;
#(
    parameter int ADDR_WIDTH             = 32,
    parameter int DATA_WIDTH             = 512,
    parameter int BURST_CNT_WIDTH        = 7,
    parameter int WAIT_REQUEST_ALLOWANCE = 0,
    parameter int MAX_RD_OUTSTANDING     = 256,
    parameter int TIMEOUT_CYCLES         = 4096
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    ofs_plat_avalon_mem_protocol_checker_if.monitor     avm,
    input  logic                                        err_clear,
    output t_err_vec                                    err_flags,
    output logic [ERR_IDX_W-1:0]                        err_first,
    output logic [31:0]                                 err_cycle,
    output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0]     rd_outstanding,
    output logic                                        wr_in_burst
);
    localparam int RD_W  = $clog2(MAX_RD_OUTSTANDING + 1);
    localparam int SUM_W = RD_W + BURST_CNT_WIDTH;
    localparam int WRA_W = $clog2(WAIT_REQUEST_ALLOWANCE + 2);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int TO_W  = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [WRA_W-1:0] WRA_MAX = WRA_W'(WAIT_REQUEST_ALLOWANCE);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    // Address and data width only matter to the link itself.
    logic unused_ok;
    assign unused_ok = ^{avm.address, 32'(DATA_WIDTH), ADDR_WIDTH[0]};

    logic [BURST_CNT_WIDTH-1:0] bc;
    logic                       cmd, cmd_acc, rd_acc, wr_acc;
    logic [WRA_W-1:0]           wra_cnt;
    logic                       wr_sop, wr_bc_change, wr_burst_zero;
    logic                       rd_dec, rd_ovf, rd_idle, to_fire;
    logic [SUM_W-1:0]           rd_sum;
    logic [TO_W-1:0]            idle_cnt;
    logic [31:0]                cyc_cnt;
    t_err_vec                   err_new, err_base;

    assign bc      = avm.burstcount;
    assign cmd     = avm.read | avm.write;
    assign cmd_acc = cmd && (!avm.waitrequest || (wra_cnt < WRA_MAX));
    assign rd_acc  = avm.read  && cmd_acc;
    assign wr_acc  = avm.write && cmd_acc;

    // Commands taken under waitrequest; saturates at the allowance.
    always_ff @(posedge clk) begin
        if (!reset_n || err_clear)                   wra_cnt <= '0;
        else if (!avm.waitrequest)                   wra_cnt <= '0;
        else if (cmd && (wra_cnt < WRA_MAX))         wra_cnt <= wra_cnt + WRA_W'(1);
    end

    ofs_plat_avalon_mem_checker_wr_tracker #(
        .BURST_CNT_WIDTH (BURST_CNT_WIDTH)
    ) wr_trk (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_acc     (wr_acc),
        .burstcount (bc),
        .sop        (wr_sop),
        .bc_change  (wr_bc_change),
        .burst_zero (wr_burst_zero),
        .in_burst   (wr_in_burst)
    );

    // A beat with nothing outstanding is an underflow and does not decrement.
    assign rd_dec  = avm.readdatavalid && (rd_outstanding != '0);
    assign rd_sum  = SUM_W'(rd_outstanding) + (rd_acc ? SUM_W'(bc) : '0) - SUM_W'(rd_dec);
    assign rd_ovf  = (rd_sum > SUM_W'(MAX_RD_OUTSTANDING));
    assign rd_idle = (rd_outstanding != '0) && !avm.readdatavalid;
    assign to_fire = TO_EN && rd_idle && (idle_cnt == TO_LAST);

    // In-flight read beats, saturating at the maximum.
    always_ff @(posedge clk) begin
        if (!reset_n)    rd_outstanding <= '0;
        else if (rd_ovf) rd_outstanding <= RD_W'(MAX_RD_OUTSTANDING);
        else             rd_outstanding <= rd_sum[RD_W-1:0];
    end

    // Consecutive cycles with reads pending and no beat; saturates so the timeout fires once.
    always_ff @(posedge clk) begin
        if (!reset_n || err_clear)        idle_cnt <= '0;
        else if (!rd_idle)                idle_cnt <= '0;
        else if (idle_cnt < TO_MAX)       idle_cnt <= idle_cnt + TO_W'(1);
    end

    // Free-running timestamp, wraps silently.
    always_ff @(posedge clk) begin
        if (!reset_n) cyc_cnt <= '0;
        else          cyc_cnt <= cyc_cnt + 32'd1;
    end

    // Error conditions observed this cycle.
    always_comb begin
        err_new                     = '0;
        err_new[ERR_RD_WR_BOTH]     = avm.read && avm.write;
        err_new[ERR_BURST_ZERO]     = wr_burst_zero || (rd_acc && (bc == '0));
        err_new[ERR_RD_IN_WR_BURST] = rd_acc && !wr_sop;
        err_new[ERR_WR_BC_CHANGE]   = wr_bc_change;
        err_new[ERR_RD_UNDERFLOW]   = avm.readdatavalid && (rd_outstanding == '0);
        err_new[ERR_RD_OVERFLOW]    = rd_ovf;
        err_new[ERR_ALLOWANCE]      = cmd && avm.waitrequest && !cmd_acc;
        err_new[ERR_RD_TIMEOUT]     = to_fire;
    end

    // A clear in the same cycle as a new error leaves only the new error.
    assign err_base = err_clear ? '0 : err_flags;

    // Sticky flags plus first-error code and timestamp.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_flags <= '0;
            err_first <= '0;
            err_cycle <= '0;
        end else begin
            err_flags <= err_base | err_new;
            if ((err_base == '0) && (err_new != '0)) begin
                err_first <= first_err_idx(err_new);
                err_cycle <= cyc_cnt;
            end else if (err_clear) begin
                err_first <= '0;
                err_cycle <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ofs_plat_avalon_mem_protocol_checker.sv
// Directed bench for the Avalon-MM protocol checker.
module tb_ofs_plat_avalon_mem_protocol_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        err_clear;
    logic [7:0]  err_flags;
    logic [2:0]  err_first;
    logic [31:0] err_cycle;
    logic [3:0]  rd_outstanding;
    logic        wr_in_burst;
    int          total = 0;
    int          bad   = 0;

    ofs_plat_avalon_mem_protocol_checker_if #(.ADDR_WIDTH(32), .BURST_CNT_WIDTH(7)) avm();

    ofs_plat_avalon_mem_protocol_checker #(
        .ADDR_WIDTH             (32),
        .DATA_WIDTH             (512),
        .BURST_CNT_WIDTH        (7),
        .WAIT_REQUEST_ALLOWANCE (2),
        .MAX_RD_OUTSTANDING     (8),
        .TIMEOUT_CYCLES         (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avm            (avm),
        .err_clear      (err_clear),
        .err_flags      (err_flags),
        .err_first      (err_first),
        .err_cycle      (err_cycle),
        .rd_outstanding (rd_outstanding),
        .wr_in_burst    (wr_in_burst)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle just after it (sample and drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        avm.waitrequest   = 1'b0;
        avm.read          = 1'b0;
        avm.write         = 1'b0;
        avm.readdatavalid = 1'b0;
        avm.address       = 32'h1000;
        avm.burstcount    = 7'd1;
        err_clear         = 1'b0;
    endtask

    // Two reset edges; the first edge after release has cycle count 0.
    task automatic do_reset();
        idle_bus();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (err_flags !== 8'h00) begin bad++; $display("FAIL reset_flags got=%h exp=00", err_flags); end
        total++; if (err_first !== 3'd0) begin bad++; $display("FAIL reset_first got=%0d exp=0", err_first); end
        total++; if (err_cycle !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", err_cycle); end
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rd_outstanding); end
        total++; if (wr_in_burst !== 1'b0) begin bad++; $display("FAIL reset_wib got=%0d exp=0", wr_in_burst); end
    endtask

    task automatic test_basic();
        do_reset();
        avm.write = 1'b1; avm.burstcount = 7'd4;
        tick();
        total++; if (wr_in_burst !== 1'b1) begin bad++; $display("FAIL basic_wib_open got=%0d exp=1", wr_in_burst); end
        repeat (3) tick();
        total++; if (wr_in_burst !== 1'b0) begin bad++; $display("FAIL basic_wib_closed got=%0d exp=0", wr_in_burst); end
        avm.write = 1'b0; avm.read = 1'b1; avm.burstcount = 7'd2;
        tick();
        total++; if (rd_outstanding !== 4'd2) begin bad++; $display("FAIL basic_rd_issue got=%0d exp=2", rd_outstanding); end
        // new read of 1 and a beat in the same cycle: net unchanged
        avm.burstcount = 7'd1; avm.readdatavalid = 1'b1;
        tick();
        total++; if (rd_outstanding !== 4'd2) begin bad++; $display("FAIL basic_rd_net got=%0d exp=2", rd_outstanding); end
        avm.read = 1'b0;
        tick();
        tick();
        avm.readdatavalid = 1'b0;
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL basic_rd_drain got=%0d exp=0", rd_outstanding); end
        total++; if (err_flags !== 8'h00) begin bad++; $display("FAIL basic_flags got=%h exp=00", err_flags); end
    endtask

    task automatic test_rd_wr_both();
        do_reset();
        repeat (10) tick();
        avm.read = 1'b1; avm.write = 1'b1; avm.burstcount = 7'd1;
        tick();
        idle_bus();
        total++; if (err_flags !== 8'h01) begin bad++; $display("FAIL both_flags got=%h exp=01", err_flags); end
        total++; if (err_first !== 3'd0) begin bad++; $display("FAIL both_first got=%0d exp=0", err_first); end
        total++; if (err_cycle !== 32'd10) begin bad++; $display("FAIL both_cycle got=%0d exp=10", err_cycle); end
    endtask

    task automatic test_allowance();
        do_reset();
        avm.waitrequest = 1'b1; avm.read = 1'b1; avm.burstcount = 7'd1;
        tick();
        tick();
        total++; if (rd_outstanding !== 4'd2) begin bad++; $display("FAIL allow_rd2 got=%0d exp=2", rd_outstanding); end
        total++; if (err_flags !== 8'h00) begin bad++; $display("FAIL allow_within got=%h exp=00", err_flags); end
        tick();
        total++; if (err_flags !== 8'h40) begin bad++; $display("FAIL allow_exceed got=%h exp=40", err_flags); end
        total++; if (rd_outstanding !== 4'd2) begin bad++; $display("FAIL allow_rd_hold got=%0d exp=2", rd_outstanding); end
        total++; if (err_first !== 3'd6) begin bad++; $display("FAIL allow_first got=%0d exp=6", err_first); end
        // one cycle without waitrequest restores the allowance
        avm.waitrequest = 1'b0; avm.read = 1'b0;
        tick();
        avm.waitrequest = 1'b1; avm.read = 1'b1;
        tick();
        idle_bus();
        total++; if (rd_outstanding !== 4'd3) begin bad++; $display("FAIL allow_reload got=%0d exp=3", rd_outstanding); end
    endtask

    task automatic test_burst_errs();
        do_reset();
        avm.write = 1'b1; avm.burstcount = 7'd4;
        tick();
        tick();
        avm.write = 1'b0; avm.read = 1'b1; avm.burstcount = 7'd1;
        tick();
        total++; if (err_flags !== 8'h04) begin bad++; $display("FAIL burst_rd_in_wr got=%h exp=04", err_flags); end
        avm.read = 1'b0; avm.write = 1'b1; avm.burstcount = 7'd3;
        tick();
        idle_bus();
        total++; if (err_flags !== 8'h0C) begin bad++; $display("FAIL burst_bc_change got=%h exp=0c", err_flags); end
        total++; if (err_first !== 3'd2) begin bad++; $display("FAIL burst_first got=%0d exp=2", err_first); end
    endtask

    task automatic test_tie();
        do_reset();
        avm.write = 1'b1; avm.burstcount = 7'd2;
        tick();
        // second beat with a read alongside: both-high and read-in-burst at once
        avm.read = 1'b1;
        tick();
        idle_bus();
        total++; if (err_flags !== 8'h05) begin bad++; $display("FAIL tie_flags got=%h exp=05", err_flags); end
        total++; if (err_first !== 3'd0) begin bad++; $display("FAIL tie_first got=%0d exp=0", err_first); end
    endtask

    task automatic test_timeout();
        do_reset();
        avm.read = 1'b1; avm.burstcount = 7'd1;
        tick();
        avm.read = 1'b0;
        repeat (15) tick();
        total++; if (err_flags !== 8'h00) begin bad++; $display("FAIL to_early got=%h exp=00", err_flags); end
        tick();
        total++; if (err_flags !== 8'h80) begin bad++; $display("FAIL to_fire got=%h exp=80", err_flags); end
        total++; if (err_first !== 3'd7) begin bad++; $display("FAIL to_first got=%0d exp=7", err_first); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        total++; if (err_flags !== 8'h00) begin bad++; $display("FAIL to_clear got=%h exp=00", err_flags); end
        total++; if (rd_outstanding !== 4'd1) begin bad++; $display("FAIL to_clear_rd got=%0d exp=1", rd_outstanding); end
        avm.readdatavalid = 1'b1;
        tick();
        avm.readdatavalid = 1'b0;
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL to_beat_rd got=%0d exp=0", rd_outstanding); end
        total++; if (err_flags !== 8'h00) begin bad++; $display("FAIL to_beat_flags got=%h exp=00", err_flags); end
    endtask

    task automatic test_underflow_clear();
        do_reset();
        avm.read = 1'b1; avm.write = 1'b1; avm.burstcount = 7'd1;
        tick();
        avm.read = 1'b0; avm.write = 1'b0; avm.readdatavalid = 1'b1;
        tick();
        total++; if (err_flags !== 8'h01) begin bad++; $display("FAIL uf_pre got=%h exp=01", err_flags); end
        err_clear = 1'b1;
        tick();
        idle_bus();
        total++; if (err_flags !== 8'h10) begin bad++; $display("FAIL uf_flags got=%h exp=10", err_flags); end
        total++; if (err_first !== 3'd4) begin bad++; $display("FAIL uf_first got=%0d exp=4", err_first); end
        total++; if (err_cycle !== 32'd2) begin bad++; $display("FAIL uf_cycle got=%0d exp=2", err_cycle); end
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL uf_rd got=%0d exp=0", rd_outstanding); end
    endtask

    task automatic test_overflow();
        do_reset();
        avm.read = 1'b1; avm.burstcount = 7'd7;
        tick();
        avm.burstcount = 7'd1;
        tick();
        total++; if (rd_outstanding !== 4'd8) begin bad++; $display("FAIL ovf_at_max got=%0d exp=8", rd_outstanding); end
        total++; if (err_flags !== 8'h00) begin bad++; $display("FAIL ovf_at_max_flags got=%h exp=00", err_flags); end
        tick();
        idle_bus();
        total++; if (rd_outstanding !== 4'd8) begin bad++; $display("FAIL ovf_sat got=%0d exp=8", rd_outstanding); end
        total++; if (err_flags !== 8'h20) begin bad++; $display("FAIL ovf_flags got=%h exp=20", err_flags); end
    endtask

    task automatic test_burst_zero();
        do_reset();
        avm.read = 1'b1; avm.burstcount = 7'd0;
        tick();
        idle_bus();
        total++; if (err_flags !== 8'h02) begin bad++; $display("FAIL bz_flags got=%h exp=02", err_flags); end
        total++; if (err_first !== 3'd1) begin bad++; $display("FAIL bz_first got=%0d exp=1", err_first); end
        total++; if (rd_outstanding !== 4'd0) begin bad++; $display("FAIL bz_rd got=%0d exp=0", rd_outstanding); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        avm.write = 1'b1; avm.burstcount = 7'd4;
        tick();
        do_reset();
        total++; if (wr_in_burst !== 1'b0) begin bad++; $display("FAIL rmb_wib got=%0d exp=0", wr_in_burst); end
        // leftover beat with a different burstcount is a fresh SOP
        avm.write = 1'b1; avm.burstcount = 7'd2;
        tick();
        total++; if (wr_in_burst !== 1'b1) begin bad++; $display("FAIL rmb_sop got=%0d exp=1", wr_in_burst); end
        tick();
        idle_bus();
        total++; if (wr_in_burst !== 1'b0) begin bad++; $display("FAIL rmb_end got=%0d exp=0", wr_in_burst); end
        total++; if (err_flags !== 8'h00) begin bad++; $display("FAIL rmb_flags got=%h exp=00", err_flags); end
    endtask

    initial begin
        idle_bus();
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_rd_wr_both();
        test_allowance();
        test_burst_errs();
        test_tie();
        test_timeout();
        test_underflow_clear();
        test_overflow();
        test_burst_zero();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
